// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: MDUOp encodings, latency
// defaults and FSM state type. The instruction decoder imports the same package.
package mult_div_unit_pkg;

    localparam int MDU_OP_W           = 4;
    localparam int MDU_MUL_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF = 10;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } mdu_state_e;

    // True for the multi-cycle ops that Start may launch.
    function automatic logic is_long_op(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Execute-stage bus between the pipeline and the multiply/divide unit:
// operands and op request in, HI/LO and Busy back.
interface mult_div_unit_if;
    import mult_div_unit_pkg::*;

    logic [31:0]         A;
    logic [31:0]         B;
    logic                Start;
    logic [MDU_OP_W-1:0] MDUOp;
    logic [31:0]         HI;
    logic [31:0]         LO;
    logic                Busy;

    modport master (output A, B, Start, MDUOp, input  HI, LO, Busy);
    modport slave  (input  A, B, Start, MDUOp, output HI, LO, Busy);

endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. Results are computed from the
// latched operands and committed only when the IDLE/RUN latency counter expires.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MUL_CYCLES = MDU_MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = MDU_DIV_CYCLES_DEF
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave mdu
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e         state_q, state_d;
    mdu_op_e            op_q,    op_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [31:0]        a_q,     a_d;
    logic [31:0]        b_q,     b_d;
    logic [31:0]        hi_q,    hi_d;
    logic [31:0]        lo_q,    lo_d;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        b_safe;
    logic [31:0]        quot_s, rem_s, quot_u, rem_u;
    logic               div_ovf;

    // Arithmetic on the latched operands; a zero divisor is replaced so the
    // dividers never see it (the commit is suppressed in that case anyway).
    always_comb begin
        prod_s  = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u  = {32'b0, a_q} * {32'b0, b_q};
        b_safe  = (b_q == 32'd0) ? 32'd1 : b_q;
        div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
        quot_u  = a_q / b_safe;
        rem_u   = a_q % b_safe;
        if (div_ovf) begin
            quot_s = 32'h8000_0000;
            rem_s  = 32'd0;
        end else begin
            quot_s = $signed(a_q) / $signed(b_safe);
            rem_s  = $signed(a_q) % $signed(b_safe);
        end
    end

    always_comb begin
        // NOTE: every _d starts from its _q, so no path through this block leaves a
        // variable unassigned and no latch is inferred.
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            ST_IDLE: begin
                if (mdu.Start && is_long_op(mdu.MDUOp)) begin
                    state_d = ST_RUN;
                    op_d    = mdu_op_e'(mdu.MDUOp);
                    a_d     = mdu.A;
                    b_d     = mdu.B;
                    cnt_d   = ((mdu.MDUOp == MDU_MULT) || (mdu.MDUOp == MDU_MULTU))
                            ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
                end else if (mdu.MDUOp == MDU_MTHI) begin
                    hi_d = mdu.A;
                end else if (mdu.MDUOp == MDU_MTLO) begin
                    lo_d = mdu.A;
                end
            end

            ST_RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    op_d    = MDU_NONE;
                    unique case (op_q)
                        MDU_MULT:  {hi_d, lo_d} = prod_s;
                        MDU_MULTU: {hi_d, lo_d} = prod_u;
                        MDU_DIV:   if (b_q != 32'd0) {hi_d, lo_d} = {rem_s, quot_s};
                        MDU_DIVU:  if (b_q != 32'd0) {hi_d, lo_d} = {rem_u, quot_u};
                        default:   ;
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the values that were present before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= MDU_NONE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign mdu.HI   = hi_q;
    assign mdu.LO   = lo_q;
    assign mdu.Busy = (state_q == ST_RUN);

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO and Busy length,
// a negedge monitor pops and compares whenever Busy falls.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        string       name;
    } exp_t;

    logic clk;
    logic reset;
    mult_div_unit_if mdu_bus ();

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mdu_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: counts Busy cycles and checks the committed result when Busy falls.
    logic busy_prev = 1'b0;
    int   busy_cnt  = 0;
    always @(negedge clk) begin
        if (!reset) begin
            busy_prev = 1'b0;
            busy_cnt  = 0;
        end else begin
            if (mdu_bus.Busy) busy_cnt++;
            if (busy_prev && !mdu_bus.Busy) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_hi"},     64'(mdu_bus.HI), 64'(e.hi));
                    check({e.name, "_lo"},     64'(mdu_bus.LO), 64'(e.lo));
                    check({e.name, "_cycles"}, 64'(busy_cnt),   64'(e.cycles));
                end
                busy_cnt = 0;
            end
            busy_prev = mdu_bus.Busy;
        end
    end

    task automatic drive_idle();
        mdu_bus.Start = 1'b0;
        mdu_bus.MDUOp = MDU_NONE;
    endtask

    // One-cycle Start pulse; returns just after the launching edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        mdu_bus.Start = 1'b1;
        mdu_bus.MDUOp = op;
        mdu_bus.A     = a;
        mdu_bus.B     = b;
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic expect_op(input string name, input logic [31:0] hi, input logic [31:0] lo,
                             input int cycles);
        exp_t e;
        e.hi = hi; e.lo = lo; e.cycles = cycles; e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!mdu_bus.Busy && sb.size() == 0) done = 1'b1;
        end
        if (!done) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
        int cyc;
        cyc = ((op == MDU_MULT) || (op == MDU_MULTU)) ? 5 : 10;
        expect_op(name, hi, lo, cyc);
        issue(op, a, b);
        wait_idle(name);
    endtask

    initial begin
        reset = 1'b0;
        mdu_bus.A = '0;
        mdu_bus.B = '0;
        drive_idle();
        #12;
        check("reset_hi",   64'(mdu_bus.HI),   64'd0);
        check("reset_lo",   64'(mdu_bus.LO),   64'd0);
        check("reset_busy", 64'(mdu_bus.Busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mult_3x5", MDU_MULT, 32'd3, 32'd5, 32'd0, 32'd15);

        // Division with HI/LO holding the previous product mid-flight.
        expect_op("div_13456_134", 32'd56, 32'd100, 10);
        issue(MDU_DIV, 32'd13456, 32'd134);
        repeat (3) @(posedge clk);
        #1;
        check("hold_hi", 64'(mdu_bus.HI), 64'd0);
        check("hold_lo", 64'(mdu_bus.LO), 64'd15);
        wait_idle("div_13456_134");

        run_op("mult_neg1x2",  MDU_MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu_max_x2", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1,         32'hFFFF_FFFE);
        run_op("div_m7_2",     MDU_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_by_zero", MDU_DIVU,  32'd7,         32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7_m2",     MDU_DIV,   32'd7, 32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
        run_op("divu_max_16",  MDU_DIVU,  32'hFFFF_FFFF, 32'd16, 32'd15,       32'h0FFF_FFFF);
        run_op("div_overflow", MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

        // Direct HI/LO writes take effect on the next edge without Busy.
        @(posedge clk); #1;
        mdu_bus.MDUOp = MDU_MTHI;
        mdu_bus.A     = 32'h1234;
        @(posedge clk); #1;
        check("mthi_hi",   64'(mdu_bus.HI),   64'h1234);
        check("mthi_busy", 64'(mdu_bus.Busy), 64'd0);
        mdu_bus.MDUOp = MDU_MTLO;
        mdu_bus.A     = 32'h5678;
        @(posedge clk); #1;
        drive_idle();
        check("mtlo_lo", 64'(mdu_bus.LO), 64'h5678);
        check("mtlo_hi", 64'(mdu_bus.HI), 64'h1234);

        // Start with a reserved op code does nothing.
        issue(4'd7, 32'd9, 32'd9);
        check("op7_busy", 64'(mdu_bus.Busy), 64'd0);
        check("op7_hilo", {mdu_bus.HI, mdu_bus.LO}, {32'h1234, 32'h5678});

        // Restart attempt and mtlo while busy are both ignored.
        expect_op("mult_ignore", 32'd1, 32'd0, 5);
        issue(MDU_MULT, 32'h0001_0000, 32'h0001_0000);
        mdu_bus.Start = 1'b1;
        mdu_bus.MDUOp = MDU_MULTU;
        mdu_bus.A     = 32'd9;
        mdu_bus.B     = 32'd9;
        @(posedge clk); #1;
        mdu_bus.Start = 1'b0;
        mdu_bus.MDUOp = MDU_MTLO;
        mdu_bus.A     = 32'hDEAD;
        @(posedge clk); #1;
        drive_idle();
        check("busy_hold_hilo", {mdu_bus.HI, mdu_bus.LO}, {32'h1234, 32'h5678});
        wait_idle("mult_ignore");

        // Asynchronous reset in the middle of a divide aborts it.
        issue(MDU_DIV, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", 64'(mdu_bus.Busy), 64'd0);
        check("abort_hilo", {mdu_bus.HI, mdu_bus.LO}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("after_abort_hilo", {mdu_bus.HI, mdu_bus.LO}, 64'd0);
        check("after_abort_busy", 64'(mdu_bus.Busy), 64'd0);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
